mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 18 +
 rtl/mem_array.sv | 32 +++
 rtl/mem_responder.sv | 161 ++++++++++++++++
 tb/tb_mem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared widths, FSM state and grant encodings for the two-port memory responder.
package mem_responder_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  typedef enum logic {
    GNT_INSTR,
    GNT_DATA
  } grant_t;

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x 8 storage: synchronous write, registered read, never reset.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              i_clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic [IW-1:0]     w_idx;

  // Any 8-bit address folds onto a valid word, so non-power-of-two depths are safe.
  assign w_idx = IW'(32'(i_addr) % 32'(DEPTH));

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[w_idx] <= i_wdata;
    end
    r_rdata <= r_mem[w_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Two-port (instruction fetch / data) memory responder with a programmable wait.
// Define MEM_RESPONDER_RR_ARB_EN for round-robin arbitration instead of data-first priority.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH       = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_pc,
  input  logic              pc_req,
  output logic [DATA_W-1:0] q_pc,
  output logic              pc_ack,
  input  logic [ADDR_W-1:0] address,
  input  logic              MemRead,
  input  logic              wren,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  output logic              d_ack,
  output logic              busy
);

  state_t            r_state;
  grant_t            r_gnt;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_isWrite;
  logic              r_pcAck;
  logic              r_dAck;
  logic [DATA_W-1:0] r_qHold;
  logic [DATA_W-1:0] r_qPcHold;
`ifdef MEM_RESPONDER_RR_ARB_EN
  grant_t            r_lastGnt;
`endif

  logic              w_dReq;
  logic              w_anyReq;
  grant_t            w_gnt;
  logic [ADDR_W-1:0] w_reqAddr;
  logic [ADDR_W-1:0] w_memAddr;
  logic              w_memWe;
  logic [DATA_W-1:0] w_rdata;
  logic              w_dReadAck;
  logic              w_pcReadAck;

  assign w_dReq   = MemRead | wren;
  assign w_anyReq = w_dReq | pc_req;

  always_comb begin
    w_gnt = GNT_INSTR;
`ifdef MEM_RESPONDER_RR_ARB_EN
    if (w_dReq && pc_req) begin
      w_gnt = (r_lastGnt == GNT_DATA) ? GNT_INSTR : GNT_DATA;
    end else if (w_dReq) begin
      w_gnt = GNT_DATA;
    end
`else
    if (w_dReq) begin
      w_gnt = GNT_DATA;
    end
`endif
  end

  assign w_reqAddr = (w_gnt == GNT_DATA) ? address : address_pc;

  // In IDLE the array is pointed at the winning request so read data is ready by the ack.
  assign w_memAddr = (r_state == ST_IDLE) ? w_reqAddr : r_addr;
  assign w_memWe   = (r_state == ST_ACK) && r_isWrite && !reset;

  mem_array #(
    .DEPTH(DEPTH)
  ) u_mem (
    .i_clock(clock),
    .i_we   (w_memWe),
    .i_addr (w_memAddr),
    .i_wdata(r_wdata),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_gnt     <= GNT_INSTR;
      r_cnt     <= 3'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_isWrite <= 1'b0;
      r_pcAck   <= 1'b0;
      r_dAck    <= 1'b0;
      r_qHold   <= '0;
      r_qPcHold <= '0;
`ifdef MEM_RESPONDER_RR_ARB_EN
      r_lastGnt <= GNT_INSTR;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pcAck <= 1'b0;
          r_dAck  <= 1'b0;
          if (w_anyReq) begin
            r_gnt     <= w_gnt;
            r_addr    <= w_reqAddr;
            r_wdata   <= data;
            r_isWrite <= (w_gnt == GNT_DATA) && wren;
            r_cnt     <= 3'(WAIT_CYCLES);
`ifdef MEM_RESPONDER_RR_ARB_EN
            r_lastGnt <= w_gnt;
`endif
            if (WAIT_CYCLES == 0) begin
              r_state <= ST_ACK;
              r_dAck  <= (w_gnt == GNT_DATA);
              r_pcAck <= (w_gnt == GNT_INSTR);
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end
          if (r_cnt <= 3'd1) begin
            r_state <= ST_ACK;
            r_dAck  <= (r_gnt == GNT_DATA);
            r_pcAck <= (r_gnt == GNT_INSTR);
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_pcAck <= 1'b0;
          r_dAck  <= 1'b0;
          if (!r_isWrite) begin
            if (r_gnt == GNT_DATA) begin
              r_qHold <= w_rdata;
            end else begin
              r_qPcHold <= w_rdata;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_pcAck <= 1'b0;
          r_dAck  <= 1'b0;
        end
      endcase
    end
  end

  // During a read's ack cycle the array output is shown directly, then latched for holding.
  assign w_dReadAck  = (r_state == ST_ACK) && !r_isWrite && (r_gnt == GNT_DATA);
  assign w_pcReadAck = (r_state == ST_ACK) && (r_gnt == GNT_INSTR);

  assign q      = w_dReadAck  ? w_rdata : r_qHold;
  assign q_pc   = w_pcReadAck ? w_rdata : r_qPcHold;
  assign pc_ack = r_pcAck;
  assign d_ack  = r_dAck;
  assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: transaction-level reference model with random traffic.
// Honours MEM_RESPONDER_RR_ARB_EN in its arbitration model.
module tb_mem_responder;

  localparam int W     = 1;
  localparam int DEPTH = 128;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] address_pc = '0;
  logic       pc_req = 1'b0;
  logic [7:0] q_pc;
  logic       pc_ack;
  logic [7:0] address = '0;
  logic       MemRead = 1'b0;
  logic       wren = 1'b0;
  logic [7:0] data = '0;
  logic [7:0] q;
  logic       d_ack;
  logic       busy;

  int checkCount = 0;
  int passCount  = 0;

  logic [7:0] model [DEPTH];
  logic [7:0] lastQ   = 8'h00;
  logic [7:0] lastQpc = 8'h00;
`ifdef MEM_RESPONDER_RR_ARB_EN
  bit lastGntData = 1'b0;
`endif

  mem_responder #(
    .WAIT_CYCLES(W),
    .DEPTH      (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .address_pc(address_pc),
    .pc_req    (pc_req),
    .q_pc      (q_pc),
    .pc_ack    (pc_ack),
    .address   (address),
    .MemRead   (MemRead),
    .wren      (wren),
    .data      (data),
    .q         (q),
    .d_ack     (d_ack),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One request burst from an idle responder: data port, instruction port, or both at once.
  task automatic applyStimulus(input bit useD, input bit dWr, input bit dRd,
                               input logic [7:0] dAddr, input logic [7:0] dData,
                               input bit useP, input logic [7:0] pAddr);
    bit         dFirst;
    bit         both;
    int         firstAck, secondAck, dAckCyc, pAckCyc, dAccCyc, pAccCyc, lastCyc;
    int         dIdx, pIdx;
    logic [7:0] newQ, newQpc;
    bit         expBusy;

    both   = useD && useP;
    dIdx   = int'(dAddr) % DEPTH;
    pIdx   = int'(pAddr) % DEPTH;
    newQ   = lastQ;
    newQpc = lastQpc;

    if (both) begin
`ifdef MEM_RESPONDER_RR_ARB_EN
      dFirst = !lastGntData;
`else
      dFirst = 1'b1;
`endif
    end else begin
      dFirst = useD;
    end

    firstAck  = W + 1;
    secondAck = 2 * W + 3;
    dAckCyc   = !useD ? -1 : (dFirst ? firstAck : secondAck);
    pAckCyc   = !useP ? -1 : (dFirst ? secondAck : firstAck);
    dAccCyc   = dFirst ? 0 : firstAck + 1;
    pAccCyc   = dFirst ? firstAck + 1 : 0;
    lastCyc   = (both ? secondAck : firstAck) + 2;

    // Reference effects in grant order; a data write commits before a later fetch.
    if (useD && dFirst) begin
      if (dWr) model[dIdx] = dData; else newQ = model[dIdx];
    end
    if (useP) newQpc = model[pIdx];
    if (useD && !dFirst) begin
      if (dWr) model[dIdx] = dData; else newQ = model[dIdx];
    end
`ifdef MEM_RESPONDER_RR_ARB_EN
    lastGntData = both ? !dFirst : useD;
`endif

    @(posedge clock); #1;
    MemRead    = useD & dRd;
    wren       = useD & dWr;
    address    = dAddr;
    data       = dData;
    pc_req     = useP;
    address_pc = pAddr;

    for (int cyc = 0; cyc <= lastCyc; cyc++) begin
      @(negedge clock);
      expBusy = (cyc >= 1 && cyc <= firstAck) || (both && cyc >= firstAck + 2 && cyc <= secondAck);
      checkOutput("d_ack", 8'(d_ack), 8'(cyc == dAckCyc));
      checkOutput("pc_ack", 8'(pc_ack), 8'(cyc == pAckCyc));
      checkOutput("busy", 8'(busy), 8'(expBusy));
      checkOutput("q", q, (useD && cyc >= dAckCyc) ? newQ : lastQ);
      checkOutput("q_pc", q_pc, (useP && cyc >= pAckCyc) ? newQpc : lastQpc);
      @(posedge clock); #1;
      if (useD && cyc == dAckCyc) begin
        MemRead = 1'b0;
        wren    = 1'b0;
      end else if (useD && cyc >= dAccCyc && cyc < dAckCyc) begin
        address = dAddr + 8'(cyc + 1);
        data    = ~dData;
      end
      if (useP && cyc == pAckCyc) begin
        pc_req = 1'b0;
      end else if (useP && cyc >= pAccCyc && cyc < pAckCyc) begin
        address_pc = pAddr + 8'(cyc + 1);
      end
    end

    lastQ   = newQ;
    lastQpc = newQpc;
  endtask

  // Abort a write by pulsing reset in its WAIT cycle.
  task automatic resetDuringWait(input logic [7:0] wAddr, input logic [7:0] wData);
    @(posedge clock); #1;
    wren    = 1'b1;
    address = wAddr;
    data    = wData;
    @(posedge clock); #1;
    reset = 1'b1;
    wren  = 1'b0;
    @(negedge clock);
    checkOutput("busy_in_wait", 8'(busy), 8'h01);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("abort_d_ack", 8'(d_ack), 8'h00);
      checkOutput("abort_busy", 8'(busy), 8'h00);
      checkOutput("abort_q", q, 8'h00);
      checkOutput("abort_q_pc", q_pc, 8'h00);
      @(posedge clock); #1;
    end
    lastQ   = 8'h00;
    lastQpc = 8'h00;
`ifdef MEM_RESPONDER_RR_ARB_EN
    lastGntData = 1'b0;
`endif
  endtask

  initial begin
    int kind;
    logic [7:0] a, b, v;

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_pc_ack", 8'(pc_ack), 8'h00);
    checkOutput("rst_d_ack", 8'(d_ack), 8'h00);
    checkOutput("rst_busy", 8'(busy), 8'h00);
    checkOutput("rst_q", q, 8'h00);
    checkOutput("rst_q_pc", q_pc, 8'h00);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(i), 8'($urandom), 1'b0, 8'h00);
    end

    applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, 8'hA5, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h00);
    checkOutput("read_back_0x10", lastQ, 8'hA5);

    applyStimulus(1'b1, 1'b1, 1'b0, 8'h05, 8'h55, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h06, 8'hAA, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 8'h00);

    applyStimulus(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 8'h06);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h30, 8'h7E, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h30, 8'h00, 1'b0, 8'h00);

    applyStimulus(1'b1, 1'b1, 1'b0, 8'h85, 8'hC3, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h05);

    resetDuringWait(8'h20, 8'h3C);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 1'b0, 8'h00);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'($urandom), 8'h00, 1'b1, 8'($urandom));
    end

    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 4));
      a = 8'($urandom);
      b = 8'($urandom);
      v = 8'($urandom);
      case (kind)
        0: applyStimulus(1'b1, 1'b0, 1'b1, a, v, 1'b0, b);
        1: applyStimulus(1'b1, 1'b1, 1'b0, a, v, 1'b0, b);
        2: applyStimulus(1'b1, 1'b1, 1'b1, a, v, 1'b0, b);
        3: applyStimulus(1'b0, 1'b0, 1'b0, a, v, 1'b1, b);
        default: applyStimulus(1'b1, 1'($urandom), 1'b1, a, v, 1'b1, b);
      endcase
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
